pp_serial_feeder: RTL

- Front-end driver for the 26x26 multiplier compressor harness.
- Accepts one operand pair (a, b) over a valid/ready handshake.
- Streams the partial-product bits, one bit per column per clock, into the per-column serial shift chain that feeds the compressor. Once all columns are loaded, it captures the compressor's 2W-bit sum and presents it over a valid/ready output handshake.

---
 rtl/pp_feeder_pkg.sv | 23 ++
 rtl/pp_column_sel.sv | 37 +++
 rtl/pp_serial_feeder.sv | 92 +++++++++
 3 files changed

// File: rtl/pp_feeder_pkg.sv
// Shared constants, state encoding and column-geometry helpers for the
// partial-product serial feeder.
package pp_feeder_pkg;

    localparam int W     = 26;
    localparam int NCOL  = 2 * W - 1;
    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, HOLD} state_t;

    // Index of the lowest multiplicand bit contributing to column k.
    function automatic int col_base(input int k, input int w);
        return (k > w - 1) ? (k - w + 1) : 0;
    endfunction

    // Number of partial-product bits landing in column k.
    function automatic int col_height(input int k, input int w);
        int hi;
        hi = (k < w - 1) ? k : (w - 1);
        return hi - col_base(k, w) + 1;
    endfunction

endpackage

// File: rtl/pp_column_sel.sv
// Per-column bit selector: picks a[i] & b[K-i] for the current shift cycle,
// right-aligned so a column's h_k bits enter the chain in its last h_k cycles.
module pp_column_sel
    import pp_feeder_pkg::*;
#(
    parameter int K = 0,
    parameter int W = 26
) (
    input  logic [W-1:0]         a_q,
    input  logic [W-1:0]         b_q,
    input  logic [$clog2(W)-1:0] cnt,
    input  logic                 active,
    output logic                 bit_o
);

    localparam int H    = col_height(K, W);
    localparam int BASE = col_base(K, W);
    localparam int OFFS = W - H;
    localparam int IW   = $clog2(W);

    logic [IW-1:0] ai;
    logic [IW-1:0] bi;
    int            j;

    always_comb begin
        bit_o = 1'b0;
        ai    = '0;
        bi    = '0;
        j     = int'(cnt) - OFFS;
        if (active && j >= 0 && j < H) begin
            ai    = IW'(BASE + j);
            bi    = IW'(K - BASE - j);
            bit_o = a_q[ai] & b_q[bi];
        end
    end

endmodule

// File: rtl/pp_serial_feeder.sv
// Loads one operand pair into the compressor's per-column shift chains over W
// cycles, then captures and hands off the 2W-bit product.
module pp_serial_feeder
    import pp_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [NCOL-1:0]   src_,
    output logic              shift_active,
    input  logic [2*W-1:0]    dst_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    result
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             shifting;

    // Column bits are combinational from the operand registers so every
    // column sees the same cnt with no inter-column skew.
    assign shifting = (state == SHIFT);

    for (genvar k = 0; k < NCOL; k++) begin : g_col
        pp_column_sel #(.K(k), .W(W)) u_col (
            .a_q    (a_q),
            .b_q    (b_q),
            .cnt    (cnt),
            .active (shifting),
            .bit_o  (src_[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result       <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            shift_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q          <= a;
                        b_q          <= b;
                        cnt          <= '0;
                        state        <= SHIFT;
                        in_ready     <= 1'b0;
                        shift_active <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == CNT_W'(W - 1)) begin
                        state        <= CAPTURE;
                        shift_active <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    result    <= dst_in;
                    state     <= HOLD;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    in_ready     <= 1'b1;
                    out_valid    <= 1'b0;
                    shift_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
